// File: rtl/ar_request_arbiter_pkg.sv
// Shared constants for the AR request arbiter: parameter defaults, packed request
// layout and burst encodings.
package ar_request_arbiter_pkg;

    localparam int BUSWIDTH_DEF = 32;
    localparam int TAGBITS_DEF  = 1;
    localparam int DEPTH_DEF    = 4;
    localparam int REQ_W        = 50;

    localparam int TAG_BIT  = 49;
    localparam int ADDR_HI  = 48;
    localparam int ADDR_LO  = 17;
    localparam int LEN_HI   = 16;
    localparam int LEN_LO   = 13;
    localparam int SIZE_HI  = 12;
    localparam int SIZE_LO  = 11;
    localparam int BURST_HI = 10;
    localparam int BURST_LO = 9;
    localparam int LOCK_HI  = 8;
    localparam int LOCK_LO  = 7;
    localparam int CACHE_HI = 6;
    localparam int CACHE_LO = 3;
    localparam int PROT_HI  = 2;
    localparam int PROT_LO  = 0;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    // Round-robin pick: 0 selects queue 0, 1 selects queue 1.
    function automatic logic rr_pick(input logic last, input logic ne0, input logic ne1);
        if (ne0 && ne1) return ~last;
        else if (ne0)   return 1'b0;
        else            return ne1;
    endfunction

endpackage

// File: rtl/ar_request_arbiter_if.sv
// AR read-address channel bundle. Valid/ready: a beat transfers on a rising edge
// where arvalid and arready are both 1; once raised, arvalid and the payload hold until then.
interface ar_request_arbiter_if
    import ar_request_arbiter_pkg::*;
#(
    parameter int BUSWIDTH = BUSWIDTH_DEF,
    parameter int TAGBITS  = TAGBITS_DEF
);
    logic [TAGBITS-1:0]  arid;
    logic [BUSWIDTH-1:0] araddr;
    logic [3:0]          arlen;
    logic [1:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready
    );
endinterface

// File: rtl/ar_request_arbiter_fifo.sv
// Per-queue request FIFO. Pushes while full are dropped even if a pop happens
// on the same edge, because full is the registered flag.
module ar_req_fifo
    import ar_request_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = REQ_W
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push) count_d = count_d + CW'(1);
        if (do_pop)  count_d = count_d - CW'(1);
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = full_q;

endmodule

// File: rtl/ar_request_arbiter.sv
// Two request queues arbitrated round-robin into a single registered AR output stage.
// A request is only visible to arbitration the edge after it is pushed.
module ar_request_arbiter
    import ar_request_arbiter_pkg::*;
#(
    parameter int BUSWIDTH = BUSWIDTH_DEF,
    parameter int TAGBITS  = TAGBITS_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                fifo0_write,
    input  logic                fifo1_write,
    input  logic [REQ_W-1:0]    AR_fifo0_in,
    input  logic [REQ_W-1:0]    AR_fifo1_in,
    output logic                fifo0_full,
    output logic                fifo1_full,
    output logic [TAGBITS-1:0]  ARID,
    output logic [BUSWIDTH-1:0] ARADDR,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic [1:0]          ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY
);
    logic [REQ_W-1:0] dout0, dout1, sel;
    logic             empty0, empty1;
    logic             load, grant;

    logic [TAGBITS-1:0]  arid_q;
    logic [BUSWIDTH-1:0] araddr_q;
    logic [3:0]          arlen_q;
    logic [1:0]          arsize_q;
    logic [1:0]          arburst_q;
    logic [1:0]          arlock_q;
    logic [3:0]          arcache_q;
    logic [2:0]          arprot_q;
    logic                arvalid_q;
    logic                last_q;

    ar_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo0 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (fifo0_write),
        .pop     (load && !grant),
        .din     (AR_fifo0_in),
        .dout    (dout0),
        .empty   (empty0),
        .full    (fifo0_full)
    );

    ar_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo1 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (fifo1_write),
        .pop     (load && grant),
        .din     (AR_fifo1_in),
        .dout    (dout1),
        .empty   (empty1),
        .full    (fifo1_full)
    );

    // The output stage refills on the same edge it hands off, so a held-high ARREADY sees no bubble.
    assign load  = (!arvalid_q || ARREADY) && (!empty0 || !empty1);
    assign grant = rr_pick(last_q, !empty0, !empty1);
    assign sel   = grant ? dout1 : dout0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arlock_q  <= '0;
            arcache_q <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            last_q    <= 1'b1;
        end else if (load) begin
            arid_q    <= sel[TAG_BIT -: TAGBITS];
            araddr_q  <= sel[ADDR_HI -: BUSWIDTH];
            arlen_q   <= sel[LEN_HI:LEN_LO];
            arsize_q  <= sel[SIZE_HI:SIZE_LO];
            arburst_q <= sel[BURST_HI:BURST_LO];
            arlock_q  <= sel[LOCK_HI:LOCK_LO];
            arcache_q <= sel[CACHE_HI:CACHE_LO];
            arprot_q  <= sel[PROT_HI:PROT_LO];
            arvalid_q <= 1'b1;
            last_q    <= grant;
        end else if (ARREADY) begin
            arvalid_q <= 1'b0;
        end
    end

    assign ARID    = arid_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = arlen_q;
    assign ARSIZE  = arsize_q;
    assign ARBURST = arburst_q;
    assign ARLOCK  = arlock_q;
    assign ARCACHE = arcache_q;
    assign ARPROT  = arprot_q;
    assign ARVALID = arvalid_q;

endmodule

// File: tb/tb_ar_request_arbiter.sv
// Bench for ar_request_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-level transaction model.
module tb_ar_request_arbiter;
    import ar_request_arbiter_pkg::*;

    localparam int W = REQ_W;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic         fifo0_write = 1'b0;
    logic         fifo1_write = 1'b0;
    logic [W-1:0] AR_fifo0_in = '0;
    logic [W-1:0] AR_fifo1_in = '0;
    logic         fifo0_full;
    logic         fifo1_full;

    ar_request_arbiter_if #(.BUSWIDTH(32), .TAGBITS(1)) ar_if ();

    ar_request_arbiter #(.BUSWIDTH(32), .TAGBITS(1), .DEPTH(4)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .fifo0_write (fifo0_write),
        .fifo1_write (fifo1_write),
        .AR_fifo0_in (AR_fifo0_in),
        .AR_fifo1_in (AR_fifo1_in),
        .fifo0_full  (fifo0_full),
        .fifo1_full  (fifo1_full),
        .ARID        (ar_if.arid),
        .ARADDR      (ar_if.araddr),
        .ARLEN       (ar_if.arlen),
        .ARSIZE      (ar_if.arsize),
        .ARBURST     (ar_if.arburst),
        .ARLOCK      (ar_if.arlock),
        .ARCACHE     (ar_if.arcache),
        .ARPROT      (ar_if.arprot),
        .ARVALID     (ar_if.arvalid),
        .ARREADY     (ar_if.arready)
    );

    always #5 ACLK = ~ACLK;

    int ncmp = 0;
    int nfail = 0;

    // Transaction-level model: two bounded queues, one output slot, last-grant index.
    logic [W-1:0] m_q0[$];
    logic [W-1:0] m_q1[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_issued[$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_last;

    function automatic logic [W-1:0] pack(input logic tag, input logic [31:0] addr,
                                          input logic [3:0] len, input logic [1:0] size,
                                          input logic [1:0] burst, input logic [1:0] lock,
                                          input logic [3:0] cache, input logic [2:0] prot);
        return {tag, addr, len, size, burst, lock, cache, prot};
    endfunction

    function automatic logic [W-1:0] dut_pkt();
        return {ar_if.arid, ar_if.araddr, ar_if.arlen, ar_if.arsize, ar_if.arburst,
                ar_if.arlock, ar_if.arcache, ar_if.arprot};
    endfunction

    function automatic logic [W-1:0] rnd_req();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        m_q0.delete();
        m_q1.delete();
        exp_q.delete();
        dut_issued.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b1;
    endtask

    task automatic model_step(input logic w0, input logic [W-1:0] x0,
                              input logic w1, input logic [W-1:0] x1, input logic rdy);
        logic fire, g;
        int s0, s1;
        fire = m_valid && rdy;
        if (fire) exp_q.push_back(m_data);
        s0 = m_q0.size();
        s1 = m_q1.size();
        if ((!m_valid || fire) && (s0 + s1 > 0)) begin
            if (s0 > 0 && s1 > 0) g = ~m_last;
            else                  g = (s0 == 0);
            m_data  = g ? m_q1.pop_front() : m_q0.pop_front();
            m_valid = 1'b1;
            m_last  = g;
        end else if (fire) begin
            m_valid = 1'b0;
        end
        if (w0 && s0 < 4) m_q0.push_back(x0);
        if (w1 && s1 < 4) m_q1.push_back(x1);
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, return at the next falling edge.
    task automatic cycle(input logic w0, input logic [W-1:0] x0,
                         input logic w1, input logic [W-1:0] x1, input logic rdy);
        fifo0_write   = w0;
        AR_fifo0_in   = x0;
        fifo1_write   = w1;
        AR_fifo1_in   = x1;
        ar_if.arready = rdy;
        if (ar_if.arvalid && rdy) dut_issued.push_back(dut_pkt());
        @(posedge ACLK);
        model_step(w0, x0, w1, x1, rdy);
        @(negedge ACLK);
        fifo0_write = 1'b0;
        fifo1_write = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        ARESETn       = 1'b0;
        fifo0_write   = 1'b0;
        fifo1_write   = 1'b0;
        ar_if.arready = 1'b0;
        model_reset();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++; if (ar_if.arvalid !== 1'b0) begin nfail++; $display("FAIL reset_arvalid got=%b exp=0", ar_if.arvalid); end
        ncmp++; if (dut_pkt() !== '0) begin nfail++; $display("FAIL reset_fields got=%h exp=0", dut_pkt()); end
        ncmp++; if ({fifo0_full, fifo1_full} !== 2'b00) begin nfail++; $display("FAIL reset_full got=%b exp=00", {fifo0_full, fifo1_full}); end
    endtask

    task automatic test_single();
        logic [W-1:0] req;
        req = pack(1'b0, 32'h0, 4'd1, 2'd1, 2'd0, 2'd1, 4'd1, 3'd1);
        do_reset();
        cycle(1'b1, req, 1'b0, '0, 1'b1);
        ncmp++; if (ar_if.arvalid !== 1'b0) begin nfail++; $display("FAIL single_no_bypass got=%b exp=0", ar_if.arvalid); end
        idle(1, 1'b1);
        ncmp++; if (ar_if.arvalid !== 1'b1) begin nfail++; $display("FAIL single_latency got=%b exp=1", ar_if.arvalid); end
        ncmp++; if (dut_pkt() !== req) begin nfail++; $display("FAIL single_payload got=%h exp=%h", dut_pkt(), req); end
        ncmp++; if ({ar_if.araddr, ar_if.arlen, ar_if.arsize} !== {32'h0, 4'd1, 2'd1}) begin
            nfail++; $display("FAIL single_fields addr=%h len=%0d size=%0d exp 0/1/1", ar_if.araddr, ar_if.arlen, ar_if.arsize);
        end
        idle(1, 1'b1);
        ncmp++; if (ar_if.arvalid !== 1'b0) begin nfail++; $display("FAIL single_one_cycle got=%b exp=0", ar_if.arvalid); end
    endtask

    task automatic test_fill_drop();
        do_reset();
        // Five fit (one in the output stage, four queued); the sixth meets a full queue.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, pack(1'b0, 32'h100 + 32'(4 * i), 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0), 1'b0, '0, 1'b0);
            if (i == 3) begin
                ncmp++; if (fifo0_full !== 1'b0) begin nfail++; $display("FAIL fill_not_full got=%b exp=0", fifo0_full); end
            end
            if (i >= 4) begin
                ncmp++; if (fifo0_full !== 1'b1) begin nfail++; $display("FAIL fill_full i=%0d got=%b exp=1", i, fifo0_full); end
            end
        end
        idle(8, 1'b1);
        ncmp++; if (dut_issued.size() != 5) begin nfail++; $display("FAIL fill_issue_count got=%0d exp=5", dut_issued.size()); end
        for (int i = 0; i < dut_issued.size() && i < 5; i++) begin
            ncmp++; if (dut_issued[i][ADDR_HI:ADDR_LO] !== 32'h100 + 32'(4 * i)) begin
                nfail++; $display("FAIL fill_order i=%0d got=%h exp=%h", i, dut_issued[i][ADDR_HI:ADDR_LO], 32'h100 + 32'(4 * i));
            end
        end
        ncmp++; if (fifo0_full !== 1'b0) begin nfail++; $display("FAIL fill_drained_full got=%b exp=0", fifo0_full); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h0, 32'h8, 32'h4, 32'hC};
        do_reset();
        cycle(1'b1, pack(1'b0, 32'h0, 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0),
              1'b1, pack(1'b1, 32'h8, 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0), 1'b0);
        cycle(1'b1, pack(1'b0, 32'h4, 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0),
              1'b1, pack(1'b1, 32'hC, 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            ncmp++; if (ar_if.arvalid !== 1'b1) begin nfail++; $display("FAIL rr_no_bubble i=%0d got=%b exp=1", i, ar_if.arvalid); end
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
        end
        idle(2, 1'b1);
        ncmp++; if (dut_issued.size() != 4) begin nfail++; $display("FAIL rr_count got=%0d exp=4", dut_issued.size()); end
        for (int i = 0; i < dut_issued.size() && i < 4; i++) begin
            ncmp++; if (dut_issued[i][ADDR_HI:ADDR_LO] !== exp_addr[i]) begin
                nfail++; $display("FAIL rr_order i=%0d got=%h exp=%h", i, dut_issued[i][ADDR_HI:ADDR_LO], exp_addr[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b;
        a = pack(1'b1, 32'h200, 4'd3, 2'd2, 2'd2, 2'd0, 4'd3, 3'd2);
        b = pack(1'b1, 32'h204, 4'd7, 2'd1, 2'd1, 2'd1, 4'd5, 3'd4);
        do_reset();
        cycle(1'b0, '0, 1'b1, a, 1'b0);
        cycle(1'b0, '0, 1'b1, b, 1'b0);
        ncmp++; if (ar_if.arvalid !== 1'b1 || dut_pkt() !== a) begin nfail++; $display("FAIL stall_hold0 valid=%b got=%h exp=%h", ar_if.arvalid, dut_pkt(), a); end
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        ncmp++; if (ar_if.arvalid !== 1'b1 || dut_pkt() !== a) begin nfail++; $display("FAIL stall_hold1 valid=%b got=%h exp=%h", ar_if.arvalid, dut_pkt(), a); end
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        ncmp++; if (ar_if.arvalid !== 1'b1 || dut_pkt() !== a) begin nfail++; $display("FAIL stall_hold2 valid=%b got=%h exp=%h", ar_if.arvalid, dut_pkt(), a); end
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        ncmp++; if (ar_if.arvalid !== 1'b1 || dut_pkt() !== b) begin nfail++; $display("FAIL stall_next valid=%b got=%h exp=%h", ar_if.arvalid, dut_pkt(), b); end
        idle(2, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        d = pack(1'b0, 32'h3F0, 4'd2, 2'd0, 2'd1, 2'd0, 4'd0, 3'd0);
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, pack(1'b0, 32'h300 + 32'(4 * i), 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0), 1'b0, '0, 1'b0);
        ncmp++; if (ar_if.arvalid !== 1'b1) begin nfail++; $display("FAIL rstmid_pre got=%b exp=1", ar_if.arvalid); end
        #2;
        ARESETn = 1'b0;
        model_reset();
        #1;
        ncmp++; if (ar_if.arvalid !== 1'b0) begin nfail++; $display("FAIL rstmid_async got=%b exp=0", ar_if.arvalid); end
        ncmp++; if (dut_pkt() !== '0) begin nfail++; $display("FAIL rstmid_fields got=%h exp=0", dut_pkt()); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
            ncmp++; if (ar_if.arvalid !== 1'b0) begin nfail++; $display("FAIL rstmid_quiet i=%0d got=%b exp=0", i, ar_if.arvalid); end
        end
        cycle(1'b1, d, 1'b0, '0, 1'b1);
        idle(1, 1'b1);
        ncmp++; if (ar_if.arvalid !== 1'b1 || dut_pkt() !== d) begin nfail++; $display("FAIL rstmid_new valid=%b got=%h exp=%h", ar_if.arvalid, dut_pkt(), d); end
        idle(2, 1'b1);
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] x;
        x = pack(1'b1, 32'h4F0, 4'd0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0);
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, pack(1'b0, 32'h400 + 32'(4 * i), 4'd0, 2'd2, 2'd1, 2'd0, 4'd0, 3'd0), 1'b0, '0, 1'b0);
        ncmp++; if (fifo0_full !== 1'b1) begin nfail++; $display("FAIL fpp_full got=%b exp=1", fifo0_full); end
        cycle(1'b1, x, 1'b0, '0, 1'b1);
        ncmp++; if (fifo0_full !== 1'b0) begin nfail++; $display("FAIL fpp_count3 full got=%b exp=0", fifo0_full); end
        idle(6, 1'b1);
        ncmp++; if (dut_issued.size() != 5) begin nfail++; $display("FAIL fpp_count got=%0d exp=5", dut_issued.size()); end
        for (int i = 0; i < dut_issued.size() && i < 5; i++) begin
            ncmp++; if (dut_issued[i][ADDR_HI:ADDR_LO] !== 32'h400 + 32'(4 * i)) begin
                nfail++; $display("FAIL fpp_order i=%0d got=%h exp=%h", i, dut_issued[i][ADDR_HI:ADDR_LO], 32'h400 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        logic w0, w1, rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            w0  = ($urandom_range(0, 99) < 45);
            w1  = ($urandom_range(0, 99) < 45);
            rdy = ($urandom_range(0, 2) != 0);
            cycle(w0, rnd_req(), w1, rnd_req(), rdy);
            ncmp++; if (ar_if.arvalid !== m_valid) begin nfail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, ar_if.arvalid, m_valid); end
            if (m_valid) begin
                ncmp++; if (dut_pkt() !== m_data) begin nfail++; $display("FAIL rand_payload c=%0d got=%h exp=%h", c, dut_pkt(), m_data); end
            end
            ncmp++; if (fifo0_full !== (m_q0.size() == 4)) begin nfail++; $display("FAIL rand_full0 c=%0d got=%b exp=%b", c, fifo0_full, m_q0.size() == 4); end
            ncmp++; if (fifo1_full !== (m_q1.size() == 4)) begin nfail++; $display("FAIL rand_full1 c=%0d got=%b exp=%b", c, fifo1_full, m_q1.size() == 4); end
        end
        idle(12, 1'b1);
        ncmp++; if (dut_issued.size() != exp_q.size()) begin nfail++; $display("FAIL rand_issue_count got=%0d exp=%0d", dut_issued.size(), exp_q.size()); end
        for (int i = 0; i < dut_issued.size() && i < exp_q.size(); i++) begin
            ncmp++; if (dut_issued[i] !== exp_q[i]) begin nfail++; $display("FAIL rand_issue i=%0d got=%h exp=%h", i, dut_issued[i], exp_q[i]); end
        end
    endtask

    initial begin
        ar_if.arready = 1'b0;
        model_reset();
        @(negedge ACLK);
        test_reset();
        test_single();
        test_fill_drop();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_full_push_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
